// File: rtl/inst_loader_pkg.sv
// Shared constants and FSM encoding for the instruction loader.
// The CHECK state exists only when INST_LOADER_CHECKSUM_EN is defined.
package inst_loader_pkg;

  localparam int          NB_DATA_DEF   = 32;
  localparam int          NB_BYTE_DEF   = 8;
  localparam int          NB_ADDR_DEF   = 7;
  localparam logic [31:0] HALT_WORD_DEF = 32'hF800_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_WRITE,
    ST_DONE
`ifdef INST_LOADER_CHECKSUM_EN
    ,
    ST_CHECK
`endif
  } state_e;

endpackage

// File: rtl/inst_loader_byte_assembler.sv
// Shifts received bytes MSB-first into a word and flags the strobe that
// completes it. The word register doubles as the memory write data.
module inst_loader_byte_assembler #(
  parameter int NB_DATA = 32,
  parameter int NB_BYTE = 8
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               shift_i,
  input  logic [NB_BYTE-1:0] byte_i,
  output logic [NB_DATA-1:0] word_o,
  output logic               word_valid_o
);

  localparam int NB_PER_WORD = NB_DATA / NB_BYTE;
  localparam int NB_CNT      = $clog2(NB_PER_WORD);

  logic [NB_DATA-1:0] word_q;
  logic [NB_CNT-1:0]  count_q;

  // NOTE: async reset in the sensitivity list, and <= for every register so
  // all flops update together from pre-edge values.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      word_q  <= '0;
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (shift_i) begin
      word_q  <= {word_q[NB_DATA-NB_BYTE-1:0], byte_i};
      count_q <= count_q + NB_CNT'(1);
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = shift_i && (count_q == NB_CNT'(NB_PER_WORD - 1));

endmodule

// File: rtl/inst_loader.sv
// Assembles UART bytes into instruction words and writes them to consecutive
// addresses until HALT or memory full. Optional checksum: INST_LOADER_CHECKSUM_EN.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int                 NB_DATA   = NB_DATA_DEF,
  parameter int                 NB_BYTE   = NB_BYTE_DEF,
  parameter int                 NB_ADDR   = NB_ADDR_DEF,
  parameter logic [NB_DATA-1:0] HALT_WORD = HALT_WORD_DEF
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic [NB_BYTE-1:0] rx_data_i,
  input  logic               rx_done_i,
  output logic               en_write_o,
  output logic [NB_ADDR-1:0] addr_write_o,
  output logic [NB_DATA-1:0] data_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               overflow_o,
  output logic               chk_err_o
);

  state_e             state_q, state_d;
  logic [NB_ADDR-1:0] addr_q, addr_d;
  logic               overflow_q, overflow_d;
  logic               accept, clear;
  logic [NB_DATA-1:0] word;
  logic               word_valid;
`ifdef INST_LOADER_CHECKSUM_EN
  logic [NB_BYTE-1:0] xor_q, xor_d;
  logic               chk_err_q, chk_err_d;
`endif

  inst_loader_byte_assembler #(
    .NB_DATA (NB_DATA),
    .NB_BYTE (NB_BYTE)
  ) u_byte_assembler (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .clear_i      (clear),
    .shift_i      (accept),
    .byte_i       (rx_data_i),
    .word_o       (word),
    .word_valid_o (word_valid)
  );

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    overflow_d = overflow_q;
    accept     = 1'b0;
    clear      = 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
    xor_d      = xor_q;
    chk_err_d  = chk_err_q;
`endif
    if (start_i) begin
      state_d    = ST_RECV;
      addr_d     = '0;
      overflow_d = 1'b0;
      clear      = 1'b1;
`ifdef INST_LOADER_CHECKSUM_EN
      xor_d      = '0;
      chk_err_d  = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_RECV: begin
          if (rx_done_i) begin
            accept = 1'b1;
`ifdef INST_LOADER_CHECKSUM_EN
            xor_d  = xor_q ^ rx_data_i;
`endif
            if (word_valid) state_d = ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (word == HALT_WORD) begin
`ifdef INST_LOADER_CHECKSUM_EN
            // A strobe in the HALT write cycle is already the checksum byte.
            if (rx_done_i) begin
              chk_err_d = (rx_data_i != xor_q);
              state_d   = ST_DONE;
            end else begin
              state_d   = ST_CHECK;
            end
`else
            state_d = ST_DONE;
`endif
          end else if (addr_q == '1) begin
            state_d    = ST_DONE;
            overflow_d = 1'b1;
          end else begin
            addr_d  = addr_q + NB_ADDR'(1);
            state_d = ST_RECV;
            if (rx_done_i) begin
              accept = 1'b1;
`ifdef INST_LOADER_CHECKSUM_EN
              xor_d  = xor_q ^ rx_data_i;
`endif
            end
          end
        end
`ifdef INST_LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (rx_done_i) begin
            chk_err_d = (rx_data_i != xor_q);
            state_d   = ST_DONE;
          end
        end
`endif
        ST_IDLE, ST_DONE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      overflow_q <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
      xor_q      <= '0;
      chk_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      overflow_q <= overflow_d;
`ifdef INST_LOADER_CHECKSUM_EN
      xor_q      <= xor_d;
      chk_err_q  <= chk_err_d;
`endif
    end
  end

  assign en_write_o   = (state_q == ST_WRITE);
  assign addr_write_o = addr_q;
  assign data_o       = word;
  assign done_o       = (state_q == ST_DONE);
  assign overflow_o   = overflow_q;
`ifdef INST_LOADER_CHECKSUM_EN
  assign busy_o       = (state_q == ST_RECV) || (state_q == ST_WRITE) || (state_q == ST_CHECK);
  assign chk_err_o    = chk_err_q;
`else
  assign busy_o       = (state_q == ST_RECV) || (state_q == ST_WRITE);
  assign chk_err_o    = 1'b0;
`endif

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: reset, load/HALT, overflow, back-to-back
// strobes, abort on restart, and the checksum when INST_LOADER_CHECKSUM_EN is set.
module tb_inst_loader;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic        start_i;
  logic [7:0]  rx_data_i;
  logic        rx_done_i;
  logic        en_write_o;
  logic [6:0]  addr_write_o;
  logic [31:0] data_o;
  logic        busy_o, done_o, overflow_o, chk_err_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [6:0]  wr_addr[$];
  logic [31:0] wr_data[$];

  inst_loader dut (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .start_i      (start_i),
    .rx_data_i    (rx_data_i),
    .rx_done_i    (rx_done_i),
    .en_write_o   (en_write_o),
    .addr_write_o (addr_write_o),
    .data_o       (data_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .overflow_o   (overflow_o),
    .chk_err_o    (chk_err_o)
  );

  always #5 clock_i = ~clock_i;

  // Write log: en_write_o is high for one full cycle, so one negedge per write.
  always @(negedge clock_i) begin
    if (en_write_o) begin
      wr_addr.push_back(addr_write_o);
      wr_data.push_back(data_o);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // All drive tasks start and end at a falling edge.
  task automatic pulse_start();
    start_i = 1'b1;
    @(negedge clock_i);
    start_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data_i = b;
    rx_done_i = 1'b1;
    @(negedge clock_i);
    rx_done_i = 1'b0;
    @(negedge clock_i);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic wait_done(input string name, input int budget);
    int cyc = 0;
    while (!done_o && cyc < budget) begin
      @(negedge clock_i);
      cyc++;
    end
    n_cmp++;
    if (done_o !== 1'b1) begin
      n_err++;
      $display("FAIL %s_done_wait: done_o=%b after %0d cycles, required 1", name, done_o, cyc);
    end
  endtask

  task automatic test_reset();
    logic [6:0] outs;
    reset_i = 1'b1; start_i = 1'b0; rx_done_i = 1'b0; rx_data_i = 8'h00;
    repeat (2) @(negedge clock_i);
    outs = {en_write_o, busy_o, done_o, overflow_o, chk_err_o, 2'b00};
    n_cmp++;
    if (outs !== 7'b0 || addr_write_o !== 7'd0 || data_o !== 32'd0) begin
      n_err++;
      $display("FAIL reset_outputs: flags=%b addr=%h data=%h, required all 0", outs, addr_write_o, data_o);
    end
    reset_i = 1'b0;
    @(negedge clock_i);
    // Reset mid-RECV after two bytes, applied between clock edges.
    pulse_start();
    send_byte(8'hAB);
    send_byte(8'hCD);
    n_cmp++;
    if (data_o !== 32'h0000ABCD || busy_o !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset_state: data=%h busy=%b, required 0000abcd busy 1", data_o, busy_o);
    end
    #2 reset_i = 1'b1;
    #1;
    outs = {en_write_o, busy_o, done_o, overflow_o, chk_err_o, 2'b00};
    n_cmp++;
    if (outs !== 7'b0 || addr_write_o !== 7'd0 || data_o !== 32'd0) begin
      n_err++;
      $display("FAIL midload_reset: flags=%b addr=%h data=%h, required all 0", outs, addr_write_o, data_o);
    end
    @(negedge clock_i);
    reset_i = 1'b0;
    @(negedge clock_i);
  endtask

  task automatic test_basic_write();
    clear_log();
    pulse_start();
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    rx_data_i = 8'h78;
    rx_done_i = 1'b1;
    @(negedge clock_i);
    rx_done_i = 1'b0;
    n_cmp++;
    if (en_write_o !== 1'b1 || addr_write_o !== 7'd0 || data_o !== 32'h12345678) begin
      n_err++;
      $display("FAIL basic_write_cycle: en=%b addr=%h data=%h, required 1 00 12345678",
               en_write_o, addr_write_o, data_o);
    end
    @(negedge clock_i);
    n_cmp++;
    if (en_write_o !== 1'b0 || addr_write_o !== 7'd1 || busy_o !== 1'b1) begin
      n_err++;
      $display("FAIL basic_after_write: en=%b addr=%h busy=%b, required 0 01 1",
               en_write_o, addr_write_o, busy_o);
    end
    n_cmp++;
    if (wr_addr.size() !== 1) begin
      n_err++;
      $display("FAIL basic_write_count: got %0d writes, required 1", wr_addr.size());
    end
  endtask

  task automatic test_halt();
    logic [31:0] exp_data[3] = '{32'h0000_0001, 32'h0000_0002, 32'hF800_0000};
    int bad = 0;
    clear_log();
    pulse_start();
    for (int i = 0; i < 3; i++) send_word(exp_data[i]);
`ifdef INST_LOADER_CHECKSUM_EN
    send_byte(8'h01 ^ 8'h02 ^ 8'hF8);
`endif
    wait_done("halt", 20);
    n_cmp++;
    if (wr_addr.size() !== 3) begin
      n_err++;
      $display("FAIL halt_write_count: got %0d writes, required 3", wr_addr.size());
    end else begin
      for (int i = 0; i < 3; i++)
        if (wr_addr[i] !== 7'(i) || wr_data[i] !== exp_data[i]) bad++;
      n_cmp++;
      if (bad != 0) begin
        n_err++;
        $display("FAIL halt_write_content: %0d wrong entries, last %h@%h required f8000000@02",
                 bad, wr_data[2], wr_addr[2]);
      end
    end
    n_cmp++;
    if (done_o !== 1'b1 || overflow_o !== 1'b0 || busy_o !== 1'b0 || chk_err_o !== 1'b0) begin
      n_err++;
      $display("FAIL halt_flags: done=%b ovf=%b busy=%b chk=%b, required 1 0 0 0",
               done_o, overflow_o, busy_o, chk_err_o);
    end
    // Bytes in DONE are ignored.
    send_word(32'h0102_0304);
    n_cmp++;
    if (wr_addr.size() !== 3 || data_o !== 32'hF800_0000 || done_o !== 1'b1) begin
      n_err++;
      $display("FAIL done_ignores_rx: writes=%0d data=%h done=%b, required 3 f8000000 1",
               wr_addr.size(), data_o, done_o);
    end
  endtask

  task automatic test_overflow();
    int bad = 0;
    clear_log();
    pulse_start();
    n_cmp++;
    if (done_o !== 1'b0 || busy_o !== 1'b1 || addr_write_o !== 7'd0) begin
      n_err++;
      $display("FAIL restart_from_done: done=%b busy=%b addr=%h, required 0 1 00",
               done_o, busy_o, addr_write_o);
    end
    for (int i = 0; i < 128; i++) send_word(32'hA500_0000 | 32'(i));
    wait_done("overflow", 20);
    n_cmp++;
    if (wr_addr.size() !== 128) begin
      n_err++;
      $display("FAIL overflow_write_count: got %0d writes, required 128", wr_addr.size());
    end else begin
      for (int i = 0; i < 128; i++)
        if (wr_addr[i] !== 7'(i) || wr_data[i] !== (32'hA500_0000 | 32'(i))) bad++;
      n_cmp++;
      if (bad != 0) begin
        n_err++;
        $display("FAIL overflow_write_content: %0d wrong entries of 128", bad);
      end
    end
    n_cmp++;
    if (overflow_o !== 1'b1 || done_o !== 1'b1 || busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL overflow_flags: ovf=%b done=%b busy=%b, required 1 1 0", overflow_o, done_o, busy_o);
    end
    send_word(32'h1111_2222);
    n_cmp++;
    if (wr_addr.size() !== 128) begin
      n_err++;
      $display("FAIL overflow_no_wrap: got %0d writes, required 128", wr_addr.size());
    end
    pulse_start();
    n_cmp++;
    if (overflow_o !== 1'b0 || done_o !== 1'b0 || addr_write_o !== 7'd0) begin
      n_err++;
      $display("FAIL overflow_cleared_on_start: ovf=%b done=%b addr=%h, required 0 0 00",
               overflow_o, done_o, addr_write_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] stream = 64'hCAFE_BABE_0BAD_F00D;
    clear_log();
    pulse_start();
    // Eight strobes on consecutive cycles; the fifth lands in the WRITE cycle.
    for (int i = 7; i >= 0; i--) begin
      rx_data_i = stream[i*8 +: 8];
      rx_done_i = 1'b1;
      @(negedge clock_i);
    end
    rx_done_i = 1'b0;
    repeat (3) @(negedge clock_i);
    n_cmp++;
    if (wr_addr.size() !== 2) begin
      n_err++;
      $display("FAIL b2b_write_count: got %0d writes, required 2", wr_addr.size());
    end else begin
      n_cmp++;
      if (wr_addr[0] !== 7'd0 || wr_data[0] !== 32'hCAFE_BABE ||
          wr_addr[1] !== 7'd1 || wr_data[1] !== 32'h0BAD_F00D) begin
        n_err++;
        $display("FAIL b2b_write_content: %h@%h %h@%h, required cafebabe@00 0badf00d@01",
                 wr_data[0], wr_addr[0], wr_data[1], wr_addr[1]);
      end
    end
  endtask

  task automatic test_abort();
    clear_log();
    pulse_start();
    for (int i = 1; i <= 4; i++) send_word(32'(i));
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    n_cmp++;
    if (wr_addr.size() !== 4 || addr_write_o !== 7'd4) begin
      n_err++;
      $display("FAIL abort_before: writes=%0d addr=%h, required 4 04", wr_addr.size(), addr_write_o);
    end
    clear_log();
    pulse_start();
    repeat (3) @(negedge clock_i);
    n_cmp++;
    if (wr_addr.size() !== 0 || busy_o !== 1'b1 || addr_write_o !== 7'd0) begin
      n_err++;
      $display("FAIL abort_partial: writes=%0d busy=%b addr=%h, required 0 1 00",
               wr_addr.size(), busy_o, addr_write_o);
    end
    send_word(32'hDEAD_BEEF);
    n_cmp++;
    if (wr_addr.size() !== 1) begin
      n_err++;
      $display("FAIL abort_write_count: got %0d writes, required 1", wr_addr.size());
    end else begin
      n_cmp++;
      if (wr_addr[0] !== 7'd0 || wr_data[0] !== 32'hDEAD_BEEF) begin
        n_err++;
        $display("FAIL abort_write_content: %h@%h, required deadbeef@00", wr_data[0], wr_addr[0]);
      end
    end
  endtask

`ifdef INST_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    logic [7:0] sum = 8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44 ^ 8'hF8;
    for (int pass = 0; pass < 2; pass++) begin
      pulse_start();
      send_word(32'h1122_3344);
      send_word(32'hF800_0000);
      n_cmp++;
      if (busy_o !== 1'b1 || done_o !== 1'b0) begin
        n_err++;
        $display("FAIL chk_waits_byte[%0d]: busy=%b done=%b, required 1 0", pass, busy_o, done_o);
      end
      send_byte(pass == 0 ? sum : 8'h00);
      wait_done("checksum", 10);
      n_cmp++;
      if (chk_err_o !== (pass == 0 ? 1'b0 : 1'b1)) begin
        n_err++;
        $display("FAIL chk_err[%0d]: got %b, required %b", pass, chk_err_o, (pass == 0 ? 1'b0 : 1'b1));
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_write();
    test_halt();
    test_overflow();
    test_back_to_back();
    test_abort();
`ifdef INST_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
